// File: rtl/fpu_sched_pkg.sv
// Shared types and default latencies for the FPU issue scheduler.
package fpu_sched_pkg;

  localparam int unsigned LAT_FADD_DEF = 2;
  localparam int unsigned LAT_FMUL_DEF = 2;
  localparam int unsigned LAT_FINV_DEF = 6;
  localparam int unsigned TAG_W_DEF    = 5;
  localparam int unsigned MAX_LAT_DEF  = 8;

  typedef enum logic [2:0] {
    OP_FADD = 3'd0,
    OP_FSUB = 3'd1,
    OP_FMUL = 3'd2,
    OP_FINV = 3'd3,
    OP_FDIV = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    WB_ADD = 2'd0,
    WB_MUL = 2'd1,
    WB_INV = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StMul  = 2'd2
  } fdiv_st_e;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_DEF-1:0] tag;
    wb_sel_e              sel;
  } rsv_slot_t;

endpackage

// File: rtl/fpu_wb_rsv.sv
// Writeback reservation shift register. Slot k (array index k-1) holds the result that
// retires k-1 cycles after the current one; the head drives writeback directly.
module fpu_wb_rsv
  import fpu_sched_pkg::*;
#(
  parameter int unsigned MAX_LAT = MAX_LAT_DEF,
  parameter int unsigned IDX_W   = $clog2(MAX_LAT + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  rsv_slot_t        wr_slot,
  input  logic [IDX_W-1:0] query_idx,
  output logic             query_free,
  output rsv_slot_t        head,
  output logic             any_valid
);

  rsv_slot_t slot_q   [MAX_LAT];
  rsv_slot_t slot_d   [MAX_LAT];
  rsv_slot_t shifted  [MAX_LAT];

  // Advance every slot one step toward the head; the tail fills with empty.
  always_comb begin
    for (int i = 0; i < MAX_LAT - 1; i++) begin
      shifted[i] = slot_q[i + 1];
    end
    shifted[MAX_LAT-1] = '0;
  end

  // Free query looks at the post-shift view so a slot vacated this cycle is reusable.
  always_comb begin
    query_free = 1'b1;
    for (int i = 0; i < MAX_LAT; i++) begin
      if (query_idx == IDX_W'(i + 1) && shifted[i].valid) begin
        query_free = 1'b0;
      end
    end
  end

  // Next-state: shifted contents plus the optional new reservation.
  always_comb begin
    for (int i = 0; i < MAX_LAT; i++) begin
      slot_d[i] = (wr_en && wr_idx == IDX_W'(i + 1)) ? wr_slot : shifted[i];
    end
  end

  // Slot storage with synchronous clear.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_LAT; i++) begin
      if (!rstn) begin
        slot_q[i] <= '0;
      end else begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  // Occupancy summary for the busy flag.
  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < MAX_LAT; i++) begin
      any_valid = any_valid | slot_q[i].valid;
    end
  end

  assign head = slot_q[0];

endmodule

// File: rtl/fpu_pipe_sched.sv
// Issue scheduler for the fixed-latency FPU pipes: reserves the shared writeback port at
// issue time and sequences FDIV as finv(y) then fmul(x, inv).
// Optional stall counter enabled by defining FPU_SCHED_PERF_EN.
module fpu_pipe_sched
  import fpu_sched_pkg::*;
#(
  parameter int unsigned LAT_FADD = LAT_FADD_DEF,
  parameter int unsigned LAT_FMUL = LAT_FMUL_DEF,
  parameter int unsigned LAT_FINV = LAT_FINV_DEF,
  parameter int unsigned TAG_W    = TAG_W_DEF,
  parameter int unsigned MAX_LAT  = MAX_LAT_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic             fadd_go,
  output logic             fadd_neg,
  output logic             fmul_go,
  output logic             fmul_src_sel,
  output logic             finv_go,
  output logic             fdiv_hold,
  output logic             wb_valid,
  output logic [TAG_W-1:0] wb_tag,
  output logic [1:0]       wb_sel,
  output logic             busy,
  output logic [31:0]      perf_stall_cnt
);

  localparam int unsigned LAT_FDIV = LAT_FINV + LAT_FMUL;
  localparam int unsigned IDX_W    = $clog2(MAX_LAT + 1);
  localparam int unsigned CNT_W    = $clog2(LAT_FINV + 1);

  if (MAX_LAT < LAT_FDIV) begin : g_chk_depth
    $error("MAX_LAT must be >= LAT_FINV + LAT_FMUL");
  end
  if (TAG_W != TAG_W_DEF) begin : g_chk_tag
    $error("TAG_W must match the package slot tag width");
  end
  if (LAT_FINV < 2 || LAT_FADD < 1 || LAT_FMUL < 1 || LAT_FADD > MAX_LAT) begin : g_chk_lat
    $error("unsupported latency configuration");
  end

  op_e              op;
  fdiv_st_e         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] rsv_idx;
  wb_sel_e          rsv_sel;
  logic             needs_rsv, blocked, query_free, accept, any_valid;
  rsv_slot_t        wr_slot, head;

  assign op = op_e'(req_op);

  // Decode the request into its writeback slot and any FDIV-sequencer hazard.
  always_comb begin
    rsv_idx   = '0;
    rsv_sel   = WB_ADD;
    needs_rsv = 1'b1;
    blocked   = 1'b0;
    case (op)
      OP_FADD, OP_FSUB: rsv_idx = IDX_W'(LAT_FADD);
      OP_FMUL: begin
        rsv_idx = IDX_W'(LAT_FMUL);
        rsv_sel = WB_MUL;
        blocked = (state_q == StMul);  // fmul pipe taken by FDIV phase 2
      end
      OP_FINV: begin
        rsv_idx = IDX_W'(LAT_FINV);
        rsv_sel = WB_INV;
      end
      OP_FDIV: begin
        rsv_idx = IDX_W'(LAT_FDIV);
        rsv_sel = WB_MUL;
        blocked = (state_q != StIdle);
      end
      // Unknown codes are consumed without issuing or reserving anything.
      default: needs_rsv = 1'b0;
    endcase
    wr_slot = '{valid: 1'b1, tag: req_tag, sel: rsv_sel};
  end

  assign req_ready = !blocked && (!needs_rsv || query_free);
  assign accept    = req_valid && req_ready;

  fpu_wb_rsv #(
    .MAX_LAT (MAX_LAT),
    .IDX_W   (IDX_W)
  ) u_rsv (
    .clk        (clk),
    .rstn       (rstn),
    .wr_en      (accept && needs_rsv),
    .wr_idx     (rsv_idx),
    .wr_slot    (wr_slot),
    .query_idx  (rsv_idx),
    .query_free (query_free),
    .head       (head),
    .any_valid  (any_valid)
  );

  // FDIV sequencer state register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FDIV sequencer next state: countdown lands StMul exactly LAT_FINV cycles after accept.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (accept && op == OP_FDIV) begin
          state_d = StWait;
          cnt_d   = CNT_W'(LAT_FINV - 1);
        end
      end
      StWait: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) state_d = StMul;
      end
      StMul:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Issue strobes for the accept cycle and the FDIV second phase.
  always_comb begin
    fadd_go      = accept && (op == OP_FADD || op == OP_FSUB);
    fadd_neg     = accept && (op == OP_FSUB);
    fmul_go      = (accept && op == OP_FMUL) || (state_q == StMul);
    fmul_src_sel = (state_q == StMul);
    finv_go      = accept && (op == OP_FINV || op == OP_FDIV);
    fdiv_hold    = accept && (op == OP_FDIV);
  end

  assign wb_valid = head.valid;
  assign wb_tag   = head.tag;
  assign wb_sel   = head.sel;
  assign busy     = any_valid || (state_q != StIdle);

`ifdef FPU_SCHED_PERF_EN
  logic [31:0] perf_q;

  // Saturating count of cycles a request waited.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_q <= '0;
    end else if (req_valid && !req_ready && perf_q != '1) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fpu_pipe_sched.sv
// Directed self-checking bench for fpu_pipe_sched.
module tb_fpu_pipe_sched;
  import fpu_sched_pkg::*;

  logic        clk;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [4:0]  req_tag;
  logic        fadd_go, fadd_neg, fmul_go, fmul_src_sel, finv_go, fdiv_hold;
  logic        wb_valid;
  logic [4:0]  wb_tag;
  logic [1:0]  wb_sel;
  logic        busy;
  logic [31:0] perf_stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // {fadd_go, fadd_neg, fmul_go, fmul_src_sel, finv_go, fdiv_hold}
  wire [5:0] go = {fadd_go, fadd_neg, fmul_go, fmul_src_sel, finv_go, fdiv_hold};
  wire [7:0] wb = {wb_valid, wb_tag, wb_sel};

  fpu_pipe_sched u_dut (
    .clk            (clk),
    .rstn           (rstn),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_tag        (req_tag),
    .fadd_go        (fadd_go),
    .fadd_neg       (fadd_neg),
    .fmul_go        (fmul_go),
    .fmul_src_sel   (fmul_src_sel),
    .finv_go        (finv_go),
    .fdiv_hold      (fdiv_hold),
    .wb_valid       (wb_valid),
    .wb_tag         (wb_tag),
    .wb_sel         (wb_sel),
    .busy           (busy),
    .perf_stall_cnt (perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at cycle 0: state already cleared, rstn high.
  task automatic do_reset();
    rstn      = 1'b0;
    req_valid = 1'b0;
    req_op    = OP_FADD;
    req_tag   = '0;
    next_cycle();
    next_cycle();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    logic [32:0] exp_perf;
    do_reset();
    #1;
    n_cmp++;
    if ({go, wb, busy} !== 15'h0) begin
      n_err++;
      $display("FAIL reset outputs got %h exp 0", {go, wb, busy});
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset req_ready got %b exp 1", req_ready);
    end
    exp_perf = '0;
    n_cmp++;
    if (perf_stall_cnt !== exp_perf[31:0]) begin
      n_err++;
      $display("FAIL reset perf got %0d exp 0", perf_stall_cnt);
    end
  endtask

  task automatic test_fadd();
    logic [5:0] exp_go;
    logic [7:0] exp_wb;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      req_valid = (c == 10);
      req_op    = OP_FADD;
      req_tag   = 5'd5;
      #1;
      exp_go = (c == 10) ? 6'b100000 : 6'b000000;
      n_cmp++;
      if (go !== exp_go) begin
        n_err++;
        $display("FAIL fadd go c=%0d got %b exp %b", c, go, exp_go);
      end
      if (c == 10) begin
        n_cmp++;
        if (req_ready !== 1'b1) begin
          n_err++;
          $display("FAIL fadd ready c=%0d got %b exp 1", c, req_ready);
        end
      end
      exp_wb = {1'b1, 5'd5, WB_ADD};
      n_cmp++;
      if ((c == 12) ? (wb !== exp_wb) : (wb_valid !== 1'b0)) begin
        n_err++;
        $display("FAIL fadd wb c=%0d got %h exp %h", c, wb, (c == 12) ? exp_wb : 8'h0);
      end
      next_cycle();
    end
    req_valid = 1'b0;
  endtask

  task automatic test_fsub();
    logic [5:0] exp_go;
    logic [7:0] exp_wb;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      req_valid = (c == 0);
      req_op    = OP_FSUB;
      req_tag   = 5'd9;
      #1;
      exp_go = (c == 0) ? 6'b110000 : 6'b000000;
      n_cmp++;
      if (go !== exp_go) begin
        n_err++;
        $display("FAIL fsub go c=%0d got %b exp %b", c, go, exp_go);
      end
      exp_wb = {1'b1, 5'd9, WB_ADD};
      n_cmp++;
      if ((c == 2) ? (wb !== exp_wb) : (wb_valid !== 1'b0)) begin
        n_err++;
        $display("FAIL fsub wb c=%0d got %h exp %h", c, wb, (c == 2) ? exp_wb : 8'h0);
      end
      next_cycle();
    end
    req_valid = 1'b0;
  endtask

  task automatic test_slot_conflict();
    logic [5:0]  exp_go;
    logic [7:0]  exp_wb;
    logic        ev;
    logic [31:0] exp_perf;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      req_valid = (c == 0 || c == 4 || c == 5);
      req_op    = (c == 0) ? OP_FINV : OP_FADD;
      req_tag   = (c == 0) ? 5'd1 : 5'd2;
      #1;
      exp_go = (c == 0) ? 6'b000010 : (c == 5) ? 6'b100000 : 6'b000000;
      n_cmp++;
      if (go !== exp_go) begin
        n_err++;
        $display("FAIL conflict go c=%0d got %b exp %b", c, go, exp_go);
      end
      if (c == 0 || c == 4 || c == 5) begin
        n_cmp++;
        if (req_ready !== (c != 4)) begin
          n_err++;
          $display("FAIL conflict ready c=%0d got %b exp %b", c, req_ready, c != 4);
        end
      end
      ev     = (c == 6 || c == 7);
      exp_wb = (c == 6) ? {1'b1, 5'd1, WB_INV} : {1'b1, 5'd2, WB_ADD};
      n_cmp++;
      if (ev ? (wb !== exp_wb) : (wb_valid !== 1'b0)) begin
        n_err++;
        $display("FAIL conflict wb c=%0d got %h exp %h", c, wb, ev ? exp_wb : 8'h0);
      end
      if (c == 8) begin
`ifdef FPU_SCHED_PERF_EN
        exp_perf = 32'd1;
`else
        exp_perf = 32'd0;
`endif
        n_cmp++;
        if (perf_stall_cnt !== exp_perf) begin
          n_err++;
          $display("FAIL perf count got %0d exp %0d", perf_stall_cnt, exp_perf);
        end
      end
      next_cycle();
    end
    req_valid = 1'b0;
  endtask

  task automatic test_fdiv();
    logic [5:0] exp_go;
    logic [7:0] exp_wb;
    logic       ev;
    do_reset();
    for (int c = 0; c < 13; c++) begin
      req_valid = (c == 0 || c == 2 || c == 6 || c == 7);
      req_op    = (c < 6) ? OP_FDIV : OP_FMUL;
      req_tag   = (c == 0) ? 5'd3 : (c == 2) ? 5'd7 : 5'd4;
      #1;
      exp_go = (c == 0) ? 6'b000011 : (c == 6) ? 6'b001100 :
               (c == 7) ? 6'b001000 : 6'b000000;
      n_cmp++;
      if (go !== exp_go) begin
        n_err++;
        $display("FAIL fdiv go c=%0d got %b exp %b", c, go, exp_go);
      end
      if (req_valid) begin
        n_cmp++;
        if (req_ready !== (c == 0 || c == 7)) begin
          n_err++;
          $display("FAIL fdiv ready c=%0d got %b exp %b", c, req_ready, c == 0 || c == 7);
        end
      end
      ev     = (c == 8 || c == 9);
      exp_wb = (c == 8) ? {1'b1, 5'd3, WB_MUL} : {1'b1, 5'd4, WB_MUL};
      n_cmp++;
      if (ev ? (wb !== exp_wb) : (wb_valid !== 1'b0)) begin
        n_err++;
        $display("FAIL fdiv wb c=%0d got %h exp %h", c, wb, ev ? exp_wb : 8'h0);
      end
      if (c == 3 || c == 11) begin
        n_cmp++;
        if (busy !== (c == 3)) begin
          n_err++;
          $display("FAIL fdiv busy c=%0d got %b exp %b", c, busy, c == 3);
        end
      end
      next_cycle();
    end
    req_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_wb;
    logic       ev;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      req_valid = (c < 8);
      req_op    = OP_FMUL;
      req_tag   = 5'(c);
      #1;
      if (c < 8) begin
        n_cmp++;
        if ({req_ready, go} !== 7'b1001000) begin
          n_err++;
          $display("FAIL b2b ready/go c=%0d got %b exp 1001000", c, {req_ready, go});
        end
      end
      ev     = (c >= 2 && c <= 9);
      exp_wb = {1'b1, 5'(c - 2), WB_MUL};
      n_cmp++;
      if (ev ? (wb !== exp_wb) : (wb_valid !== 1'b0)) begin
        n_err++;
        $display("FAIL b2b wb c=%0d got %h exp %h", c, wb, ev ? exp_wb : 8'h0);
      end
      next_cycle();
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [5:0] exp_go;
    do_reset();
    for (int c = 0; c < 13; c++) begin
      rstn      = (c != 3);
      req_valid = (c == 0);
      req_op    = OP_FDIV;
      req_tag   = 5'd3;
      #1;
      exp_go = (c == 0) ? 6'b000011 : 6'b000000;
      n_cmp++;
      if (go !== exp_go) begin
        n_err++;
        $display("FAIL rstmid go c=%0d got %b exp %b", c, go, exp_go);
      end
      if (c >= 4) begin
        n_cmp++;
        if (wb_valid !== 1'b0) begin
          n_err++;
          $display("FAIL rstmid wb_valid c=%0d got %b exp 0", c, wb_valid);
        end
      end
      if (c == 4) begin
        n_cmp++;
        if ({busy, req_ready} !== 2'b01) begin
          n_err++;
          $display("FAIL rstmid busy/ready got %b exp 01", {busy, req_ready});
        end
      end
      next_cycle();
    end
    req_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fadd();
    test_fsub();
    test_slot_conflict();
    test_fdiv();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
